// File: rtl/pmod_hexpad_emulator.sv
// Emulates a 16-key PMOD hex keypad: queued key codes are "pressed" one at a
// time by pulling the key's row low while the scanner strobes its column.
module pmod_hexpad_emulator #(
    parameter int PRESS_CYCLES = 1_000_000,
    parameter int GAP_CYCLES   = 1_000_000,
    parameter int FIFO_AW      = 2,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       busy,
    output logic [7:0] keys_sent
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [3:0]         cur_key_q, cur_key_d;
    logic [7:0]         keys_sent_q, keys_sent_d;

    logic [3:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_next;
    logic               full_q, empty_q;
    logic               push, pop;

    logic [1:0]         cur_r, cur_c;

    // Packs the keypad position of a code as {row index, column index}.
    function automatic logic [3:0] key_pos(input logic [3:0] k);
        logic [3:0] pos;
        case (k)
            4'h1: pos = 4'b00_00;
            4'h2: pos = 4'b00_01;
            4'h3: pos = 4'b00_10;
            4'hA: pos = 4'b00_11;
            4'h4: pos = 4'b01_00;
            4'h5: pos = 4'b01_01;
            4'h6: pos = 4'b01_10;
            4'hB: pos = 4'b01_11;
            4'h7: pos = 4'b10_00;
            4'h8: pos = 4'b10_01;
            4'h9: pos = 4'b10_10;
            4'hC: pos = 4'b10_11;
            4'h0: pos = 4'b11_00;
            4'hF: pos = 4'b11_01;
            4'hE: pos = 4'b11_10;
            default: pos = 4'b11_11;
        endcase
        return pos;
    endfunction

    assign push       = key_valid & ~full_q;
    assign count_next = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= key_in;
        end
    end

    // Flags are registered from the next count so key_ready has no comb path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_next;
            full_q  <= (count_next == (FIFO_AW+1)'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            cur_key_q   <= '0;
            keys_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            cur_key_q   <= cur_key_d;
            keys_sent_q <= keys_sent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        cur_key_d   = cur_key_q;
        keys_sent_d = keys_sent_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop       = 1'b1;
                    cur_key_d = mem[rd_ptr_q];
                    counter_d = '0;
                    state_d   = PRESS;
                end
            end
            PRESS: begin
                if (counter_q == CNT_W'(PRESS_CYCLES - 1)) begin
                    counter_d   = '0;
                    keys_sent_d = keys_sent_q + 8'd1;
                    state_d     = GAP;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            GAP: begin
                if (counter_q == CNT_W'(GAP_CYCLES - 1)) begin
                    counter_d = '0;
                    state_d   = IDLE;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign {cur_r, cur_c} = key_pos(cur_key_q);

    // Index 3-x on a 2-bit index is its bitwise inverse.
    always_comb begin
        row = 4'b1111;
        if (state_q == PRESS && col[~cur_c] == 1'b0) begin
            row[~cur_r] = 1'b0;
        end
    end

    assign key_ready = ~full_q;
    assign busy      = (state_q != IDLE) | ~empty_q;
    assign keys_sent = keys_sent_q;

endmodule

// File: tb/tb_pmod_hexpad_emulator.sv
// Directed bench for pmod_hexpad_emulator with short press/gap timing.
module tb_pmod_hexpad_emulator;

    localparam int PRESS = 8;
    localparam int GAP   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic [7:0] keys_sent;

    int tests_run    = 0;
    int tests_failed = 0;

    // Hand-derived keypad table: column strobe and row return for each code.
    logic [3:0] exp_col [16] = '{4'b0111, 4'b0111, 4'b1011, 4'b1101,
                                 4'b0111, 4'b1011, 4'b1101, 4'b0111,
                                 4'b1011, 4'b1101, 4'b1110, 4'b1110,
                                 4'b1110, 4'b1110, 4'b1101, 4'b1011};
    logic [3:0] exp_row [16] = '{4'b1110, 4'b0111, 4'b0111, 4'b0111,
                                 4'b1011, 4'b1011, 4'b1011, 4'b1101,
                                 4'b1101, 4'b1101, 4'b0111, 4'b1011,
                                 4'b1101, 4'b1110, 4'b1110, 4'b1110};
    logic [3:0] probe [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    int seq_key [16];
    int seq_len [16];
    int gap_len [16];
    int n_seq;
    int n_gap;

    always #5 clk = ~clk;

    pmod_hexpad_emulator #(
        .PRESS_CYCLES(PRESS),
        .GAP_CYCLES  (GAP),
        .FIFO_AW     (2),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_in   (key_in),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .col      (col),
        .row      (row),
        .busy     (busy),
        .keys_sent(keys_sent)
    );

    task automatic push_key(input logic [3:0] k, output bit ok);
        key_in    = k;
        key_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (key_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        key_valid = 1'b0;
    endtask

    task automatic watch_press(input logic [3:0] c, output logic [3:0] first_row,
                               output int len, output bit seen);
        col       = c;
        seen      = 1'b0;
        len       = 0;
        first_row = 4'hF;
        for (int i = 0; i < 300 && !seen; i++) begin
            #1;
            if (row !== 4'hF) begin
                seen      = 1'b1;
                first_row = row;
            end else begin
                @(negedge clk);
            end
        end
        while (seen && row === first_row && len < 100) begin
            len++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        col       = 4'b0000;
        key_valid = 1'b0;
        key_in    = 4'h0;
        #3;
        tests_run++;
        if (row !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL reset_row: got %b expected 1111", row);
        end
        tests_run++;
        if (key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_key_ready: got %b expected 1", key_ready);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (keys_sent !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_keys_sent: got %0d expected 0", keys_sent);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_key;
        bit ok;
        bit bad_other;
        bit bad_row;
        int press_cnt;
        int first_idx;
        int last_idx;
        bad_other = 1'b0;
        bad_row   = 1'b0;
        press_cnt = 0;
        first_idx = -1;
        last_idx  = -1;
        push_key(4'h4, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL single_push: accepted %b expected 1", ok);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            for (int p = 1; p < 4; p++) begin
                col = probe[p];
                #1;
                if (row !== 4'b1111) bad_other = 1'b1;
            end
            col = 4'b0111;
            #1;
            if (row === 4'b1011) begin
                press_cnt++;
                if (first_idx < 0) first_idx = cyc;
                last_idx = cyc;
            end else if (row !== 4'b1111) begin
                bad_row = 1'b1;
            end
            @(negedge clk);
        end
        tests_run++;
        if (bad_other) begin
            tests_failed++;
            $display("[TB] FAIL single_other_cols: row low on wrong column, expected 1111");
        end
        tests_run++;
        if (bad_row) begin
            tests_failed++;
            $display("[TB] FAIL single_row_value: row not 1011/1111 on col 0111");
        end
        tests_run++;
        if (press_cnt != PRESS || (last_idx - first_idx + 1) != PRESS) begin
            tests_failed++;
            $display("[TB] FAIL single_press_len: got %0d cycles span %0d expected %0d",
                     press_cnt, last_idx - first_idx + 1, PRESS);
        end
        tests_run++;
        if (keys_sent !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_keys_sent: got %0d expected 1", keys_sent);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_full_map;
        bit ok;
        bit seen;
        logic [3:0] r;
        int len;
        for (int k = 0; k < 16; k++) begin
            push_key(4'(k), ok);
            watch_press(exp_col[k], r, len, seen);
            tests_run++;
            if (!ok || !seen || r !== exp_row[k] || len != PRESS) begin
                tests_failed++;
                $display("[TB] FAIL map_key_%h: push %b seen %b row %b len %0d expected row %b len %0d",
                         k, ok, seen, r, len, exp_row[k], PRESS);
            end
            wait_idle(ok);
        end
        tests_run++;
        if (keys_sent !== 8'd17) begin
            tests_failed++;
            $display("[TB] FAIL map_keys_sent: got %0d expected 17", keys_sent);
        end
    endtask

    task automatic test_back_to_back;
        int keys [6] = '{1, 5, 9, 13, 2, 12};
        bit all_ok;
        bit ready_low;
        bit ok;
        all_ok    = 1'b1;
        ready_low = 1'b0;
        n_seq     = 0;
        n_gap     = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bit got;
                    key_in    = 4'(keys[i]);
                    key_valid = 1'b1;
                    got       = 1'b0;
                    for (int j = 0; j < 100; j++) begin
                        if (key_ready === 1'b1) got = 1'b1;
                        @(negedge clk);
                        if (got) break;
                    end
                    if (!got) all_ok = 1'b0;
                    if (i == 4) ready_low = (key_ready === 1'b0);
                end
                key_valid = 1'b0;
            end
            begin
                int cur;
                int run;
                bit had_press;
                cur       = -1;
                run       = 0;
                had_press = 1'b0;
                for (int t = 0; t < 140; t++) begin
                    int det;
                    @(negedge clk);
                    det = -1;
                    for (int p = 0; p < 4; p++) begin
                        col = probe[p];
                        #1;
                        if (row !== 4'hF) begin
                            for (int kk = 0; kk < 16; kk++) begin
                                if (exp_col[kk] == probe[p] && exp_row[kk] == row) det = kk;
                            end
                        end
                    end
                    if (det == cur) begin
                        run++;
                    end else begin
                        if (cur >= 0 && n_seq < 16) begin
                            seq_key[n_seq] = cur;
                            seq_len[n_seq] = run;
                            n_seq++;
                            had_press = 1'b1;
                        end else if (had_press && n_gap < 16) begin
                            gap_len[n_gap] = run;
                            n_gap++;
                        end
                        cur = det;
                        run = 1;
                    end
                end
                if (cur >= 0 && n_seq < 16) begin
                    seq_key[n_seq] = cur;
                    seq_len[n_seq] = run;
                    n_seq++;
                end
            end
        join
        tests_run++;
        if (!all_ok) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accept: not all 6 keys accepted within bound");
        end
        tests_run++;
        if (!ready_low) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready_drop: key_ready %b after 5 pushes expected 0", key_ready);
        end
        tests_run++;
        if (n_seq != 6) begin
            tests_failed++;
            $display("[TB] FAIL b2b_press_count: got %0d presses expected 6", n_seq);
        end
        for (int i = 0; i < 6 && i < n_seq; i++) begin
            tests_run++;
            if (seq_key[i] != keys[i] || seq_len[i] != PRESS) begin
                tests_failed++;
                $display("[TB] FAIL b2b_press_%0d: key %h len %0d expected key %h len %0d",
                         i, seq_key[i], seq_len[i], keys[i], PRESS);
            end
        end
        // Between queued presses: GAP cycles plus the one IDLE cycle that pops.
        for (int i = 0; i < 5 && i < n_gap; i++) begin
            tests_run++;
            if (gap_len[i] != GAP + 1) begin
                tests_failed++;
                $display("[TB] FAIL b2b_gap_%0d: got %0d idle cycles expected %0d",
                         i, gap_len[i], GAP + 1);
            end
        end
        wait_idle(ok);
        tests_run++;
        if (!ok || keys_sent !== 8'd23) begin
            tests_failed++;
            $display("[TB] FAIL b2b_end: idle %b keys_sent %0d expected idle 1 keys_sent 23",
                     ok, keys_sent);
        end
    endtask

    task automatic test_reset_mid_press;
        bit ok1;
        bit ok2;
        bit seen;
        bit stray;
        logic [3:0] r;
        int len;
        push_key(4'h7, ok1);
        push_key(4'h8, ok2);
        col  = 4'b0111;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            #1;
            if (row !== 4'hF) seen = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (!ok1 || !ok2 || !seen || row !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL midreset_row: pushed %b%b seen %b row %b expected 1111",
                     ok1, ok2, seen, row);
        end
        tests_run++;
        if (busy !== 1'b0 || key_ready !== 1'b1 || keys_sent !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_state: busy %b ready %b keys_sent %0d expected 0 1 0",
                     busy, key_ready, keys_sent);
        end
        @(negedge clk);
        reset = 1'b0;
        col   = 4'b0000;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (row !== 4'hF || busy !== 1'b0) stray = 1'b1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("[TB] FAIL midreset_queue: activity after reset, expected empty queue");
        end
        push_key(4'h5, ok1);
        watch_press(4'b1011, r, len, seen);
        tests_run++;
        if (!ok1 || !seen || r !== 4'b1011 || len != PRESS) begin
            tests_failed++;
            $display("[TB] FAIL midreset_repush: seen %b row %b len %0d expected row 1011 len %0d",
                     seen, r, len, PRESS);
        end
        wait_idle(ok1);
        tests_run++;
        if (keys_sent !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_keys_sent: got %0d expected 1", keys_sent);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        col    = 4'b1111;
        for (int i = 0; i < 254; i++) begin
            push_key(4'(i), ok);
            if (!ok) all_ok = 1'b0;
        end
        wait_idle(ok);
        tests_run++;
        if (!all_ok || !ok || keys_sent !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL wrap_255: pushes %b idle %b keys_sent %0d expected 255",
                     all_ok, ok, keys_sent);
        end
        push_key(4'hE, ok);
        wait_idle(all_ok);
        tests_run++;
        if (!ok || !all_ok || keys_sent !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_zero: keys_sent %0d expected 0", keys_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_full_map();
        test_back_to_back();
        test_reset_mid_press();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
